booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//  Iterative radix-4 Booth multiplier, parametrised successor of the combinational
//  16x16 booth_mult. Retires 2 multiplier bits per cycle; adds a valid/ready handshake
//  and a per-operation signed/unsigned mode. Drop-in arithmetic engine for
//  area-constrained datapaths where multi-cycle latency is acceptable.
// PARAMETERS
//  W     16   operand width in bits; even, >= 4 (elaboration error otherwise)
//  ITER  W/2+1 (derived localparam, not overridable) Booth iterations per operation
// PORTS
//  clk         in   1    single clock; all state updates on rising edge
//  rst         in   1    synchronous, active-high reset
//  in_valid    in   1    operands + mode present
//  in_ready    out  1    engine can accept an operation
//  signed_mode in   1    1: a,b two's complement; 0: a,b unsigned
//  a           in   W    multiplicand
//  b           in   W    multiplier
//  out_valid   out  1    p holds a completed product
//  out_ready   in   1    consumer takes the product
//  p           out  2W   product (two's complement if signed_mode, else unsigned)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, in_ready=1, out_valid=0, p=0, counter=0,
//   internal regs cleared. Reset mid-RUN or in DONE aborts; the result is discarded.
//  FSM: IDLE -> RUN on (in_valid & in_ready); RUN -> DONE when counter==ITER-1;
//   DONE -> IDLE on out_ready. in_ready = (state==IDLE); out_valid = (state==DONE).
//  Accept edge: capture a, b, signed_mode; extend both to W+2 bits (sign-extend if
//   signed_mode, else zero-extend); accumulator=0; counter=0.
//  RUN, one iteration per cycle: encode multiplier triplet {b[2i+1],b[2i],b[2i-1]}
//   (b[-1]=0) into a digit in {-2,-1,0,+1,+2}; add digit*a, shifted left by 2i, to the
//   2W+4-bit accumulator; counter++. Negation is one's complement plus carry-in.
//  Same ITER for both modes -> fixed latency: out_valid rises exactly ITER cycles
//   after the accept edge (9 cycles for W=16).
//  Entering DONE: p <= accumulator[2W-1:0]. p is stable through DONE and holds its
//   value in IDLE until the next result is written; it never changes while out_valid=1.
//  Operand inputs are ignored outside the accept edge; in_valid while busy is not
//   stored (the producer must hold it until in_ready).
//  out_ready outside DONE: no effect. in_valid and out_ready both high in DONE:
//   the product retires; the new operation is accepted no earlier than the next cycle
//   (in IDLE). Maximum throughput: one result per ITER+2 cycles.
//  Overflow is impossible: 2W bits hold every signed and unsigned W x W product,
//   including (-2^(W-1))^2 = 2^(2W-2) and (2^W-1)^2.
// STRUCTURE
//  booth_pkg: state enum {IDLE,RUN,DONE}; Booth digit encoding (neg, one, two flags);
//   function for the triplet-to-digit mapping shared with the combinational booth_mult.
//  Sub-module booth_r4_enc: 3-bit triplet -> {neg,one,two}, purely combinational.
//  Top level: FSM, iteration counter, operand/accumulator registers, one adder.
// TESTING (W=16)
//  signed, a=25, b=-2 -> out_valid exactly 9 cycles after accept; p=32'hFFFF_FFCE (-50)
//  signed, a=16'h7FFF, b=16'h7FFF -> p=32'h3FFF_0001; a=16'h8000, b=16'h7FFF -> 32'hC000_8000
//  unsigned, a=16'hFFFF, b=16'hFFFF -> p=32'hFFFE_0001; signed same operands -> 32'h0000_0001
//  backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, p stable, in_ready=0;
//   in_valid pulsed during RUN -> ignored, no second result
//  rst asserted on the 4th RUN cycle -> next cycle IDLE, out_valid=0, p=0; a new op
//   (58 x -98 signed) then yields p=32'hFFFF_E9CC (-5684)
//  random regression: 10k signed/unsigned ops vs $signed/$unsigned reference model,
//   random in_valid/out_ready gaps, plus W=8 and W=32 builds

Source files
------------

// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared types for the radix-4 Booth multipliers.
//   state_t        : sequencer states of booth_mult_seq
//   booth_digit_t  : one Booth digit as {neg, one, two} flags
//   booth_encode() : multiplier triplet {b[2i+1], b[2i], b[2i-1]} -> digit.
//                    The same mapping is used by the combinational booth_mult.
// ---------------------------------------------------------------------------
package booth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // digit = (neg ? -1 : +1) * (two ? 2 : one ? 1 : 0)
   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } booth_digit_t;

   function automatic booth_digit_t booth_encode(input logic [2:0] t);
      booth_digit_t d;
      // 3'b111 is -0: neg is kept low so no stray carry-in enters the adder
      d.neg = t[2] & ~(t[1] & t[0]);
      d.one = t[1] ^ t[0];
      d.two = (t == 3'b011) || (t == 3'b100);
      return d;
   endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// ---------------------------------------------------------------------------
// booth_r4_enc
// Purely combinational radix-4 Booth recoder.
//   i_triplet [2:0] : {b[2i+1], b[2i], b[2i-1]}
//   o_digit         : {neg, one, two} flags for that digit
// ---------------------------------------------------------------------------
module booth_r4_enc
   import booth_pkg::*;
(
   input  logic [2:0]   i_triplet,
   output booth_digit_t o_digit
);

   assign o_digit = booth_encode(i_triplet);

endmodule

// File: rtl/booth_mult_seq.sv
// ---------------------------------------------------------------------------
// booth_mult_seq
// Iterative radix-4 Booth multiplier, 2 multiplier bits retired per cycle.
// Fixed latency: out_valid rises ITER = W/2+1 cycles after the accept edge,
// for both signed and unsigned operations.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : operands + mode present       in_ready  : engine idle
//   signed_mode  : 1 two's complement, 0 unsigned
//   a, b [W-1:0] : multiplicand, multiplier
//   out_valid    : p holds a completed product   out_ready : consumer takes p
//   p [2W-1:0]   : product
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for in_valid; in_ready=1; p holds the last result
// ST_RUN  | one Booth iteration per cycle, r_cnt = iteration index
// ST_DONE | out_valid=1, p stable until out_ready
// ---------------------------------------------------------------------------
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int W = 16
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           signed_mode,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] p
);

   localparam int ITER = W/2 + 1;
   localparam int AW   = 2*W + 4;
   localparam int XW   = W + 2;
   localparam int CW   = $clog2(ITER + 1);

   if ((W % 2) != 0 || W < 4) begin : g_bad_w
      $error("booth_mult_seq: W must be even and >= 4");
   end

   state_t         r_state;
   logic           r_in_ready;
   logic           r_out_valid;
   logic [2*W-1:0] r_p;
   logic [AW-1:0]  r_acc;
   logic [AW-1:0]  r_mcand;
   logic [XW:0]    r_mplier;
   logic [CW-1:0]  r_cnt;

   logic [AW-1:0]  w_a_ext;
   logic [XW-1:0]  w_b_ext;
   booth_digit_t   w_digit;
   logic [AW-1:0]  w_addend;
   logic [AW-1:0]  w_acc_next;

   // Multiplicand is extended straight to accumulator width; the value is the
   // same as a W+2-bit extension, and it removes per-iteration sign fill.
   assign w_a_ext = signed_mode ? {{(AW-W){a[W-1]}}, a} : {{(AW-W){1'b0}}, a};
   assign w_b_ext = signed_mode ? {{(XW-W){b[W-1]}}, b} : {{(XW-W){1'b0}}, b};

   // r_mplier shifts right by 2 each iteration, so the current triplet is
   // always at [2:0]; bit 0 at accept time is the implicit b[-1]=0.
   booth_r4_enc u_enc (
      .i_triplet (r_mplier[2:0]),
      .o_digit   (w_digit)
   );

   // r_mcand shifts left by 2 each iteration, carrying the 4^i weight.
   assign w_addend = w_digit.two ? {r_mcand[AW-2:0], 1'b0} :
                     w_digit.one ? r_mcand : '0;

   // Negation as one's complement with the +1 folded in as carry-in.
   assign w_acc_next = r_acc + (w_addend ^ {AW{w_digit.neg}}) + AW'(w_digit.neg);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_p         <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_mcand    <= w_a_ext;
                  r_mplier   <= {w_b_ext, 1'b0};
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_acc    <= w_acc_next;
               r_mcand  <= {r_mcand[AW-3:0], 2'b00};
               r_mplier <= {2'b00, r_mplier[XW:2]};
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == CW'(ITER - 1)) begin
                  r_p         <= w_acc_next[2*W-1:0];
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign p         = r_p;

endmodule

// File: tb/tb_booth_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_seq
// Directed-vector bench for booth_mult_seq (W=16) with hand-computed products.
// ---------------------------------------------------------------------------
module tb_booth_mult_seq;

   localparam int W = 16;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic           signed_mode;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] p;

   int n_checks;
   int n_fail;

   booth_mult_seq #(.W(W)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .signed_mode (signed_mode),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .p           (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
   endtask

   // Launch one op (returns right after the accept edge).
   task automatic launch(input logic sm, input logic [W-1:0] va, input logic [W-1:0] vb);
      wait_ready();
      signed_mode = sm;
      a           = va;
      b           = vb;
      in_valid    = 1'b1;
      tick();
      in_valid    = 1'b0;
      a           = '0;
      b           = '0;
   endtask

   task automatic retire();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic sm, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic [2*W-1:0] exp);
      int n;
      launch(sm, va, vb);
      wait_valid(n);
      chk({tag, "_lat"}, 64'(n), 64'd9);
      chk({tag, "_p"}, 64'(p), 64'(exp));
      retire();
   endtask

   initial begin
      int n;
      int seen;
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      signed_mode = 1'b0;
      a           = '0;
      b           = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_p", 64'(p), 64'd0);

      // directed products
      run_op("s_25xm2",    1'b1, 16'd25,    16'hFFFE, 32'hFFFF_FFCE);
      chk("retire_out_valid", 64'(out_valid), 64'd0);
      chk("retire_in_ready", 64'(in_ready), 64'd1);
      chk("idle_p_hold", 64'(p), 64'h0000_0000_FFFF_FFCE);
      run_op("s_max_max",  1'b1, 16'h7FFF,  16'h7FFF, 32'h3FFF_0001);
      run_op("s_min_max",  1'b1, 16'h8000,  16'h7FFF, 32'hC000_8000);
      run_op("u_ffff",     1'b0, 16'hFFFF,  16'hFFFF, 32'hFFFE_0001);
      run_op("s_m1_m1",    1'b1, 16'hFFFF,  16'hFFFF, 32'h0000_0001);
      run_op("s_min_min",  1'b1, 16'h8000,  16'h8000, 32'h4000_0000);
      run_op("u_8000",     1'b0, 16'h8000,  16'h8000, 32'h4000_0000);
      run_op("u_1234x5678",1'b0, 16'd1234,  16'd5678, 32'h006A_E9BC);
      run_op("s_0xm5",     1'b1, 16'd0,     16'hFFFB, 32'h0000_0000);
      run_op("u_1x0",      1'b0, 16'hFFFF,  16'd1,    32'h0000_FFFF);

      // backpressure + in_valid pulsed during RUN
      launch(1'b1, 16'd3, 16'hFFF9);
      chk("run_in_ready", 64'(in_ready), 64'd0);
      tick();
      tick();
      signed_mode = 1'b0;
      a           = 16'd100;
      b           = 16'd100;
      in_valid    = 1'b1;
      tick();
      in_valid    = 1'b0;
      wait_valid(n);
      chk("bp_p", 64'(p), 64'h0000_0000_FFFF_FFEB);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_p_stable", 64'(p), 64'h0000_0000_FFFF_FFEB);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      retire();
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid || !in_ready) seen = 1;
      end
      chk("no_second_result", 64'(seen), 64'd0);

      // in_valid and out_ready together in DONE: retire first, accept one cycle later
      launch(1'b1, 16'd7, 16'd6);
      wait_valid(n);
      chk("ovl_p1", 64'(p), 64'd42);
      signed_mode = 1'b1;
      a           = 16'hFFF6;
      b           = 16'd9;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("ovl_retired", 64'(out_valid), 64'd0);
      chk("ovl_not_yet_accepted", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("ovl_accepted", 64'(in_ready), 64'd0);
      wait_valid(n);
      chk("ovl_lat", 64'(n), 64'd9);
      chk("ovl_p2", 64'(p), 64'h0000_0000_FFFF_FFA6);
      retire();

      // reset on the 4th RUN cycle aborts
      launch(1'b1, 16'd11, 16'd13);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_p", 64'(p), 64'd0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) seen = 1;
      end
      chk("abort_no_result", 64'(seen), 64'd0);
      run_op("s_58xm98", 1'b1, 16'd58, 16'hFF9E, 32'hFFFF_E9CC);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
